multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL provide these parameters, one per line (name, default, meaning):
- MEM_WAIT_EN, 1, 1 = honour mem_ready wait states; 0 = treat mem_ready as always 1.
- EN_BNE, 1, 1 = decode bne (op 0x05); 0 = op 0x05 is illegal.
- EN_JAL, 1, 1 = decode jal (op 0x03); 0 = op 0x03 is illegal.
- CNT_W, 32, width of retire counter.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-low reset.
- op, in, 6, opcode from the instruction register (IR).
- zero, in, 1, ALU zero flag.
- mem_ready, in, 1, memory access completes this cycle.
- PCWrite / PCWriteCond / IorD / MemRead / MemWrite / IRWrite / RegWrite / ALUSrcA / BranchNe, out, 1 each, datapath strobes.
- RegDst / MemtoReg / ALUSrcB / PCSource / EXTOp / ALUOp, out, 2 each, datapath selects.
- instr_done, out, 1, one-cycle pulse on the final cycle of each instruction.
- illegal, out, 1, sticky illegal-opcode flag.
- retire_cnt, out, CNT_W, count of completed instructions.

Function
REQ-003 The block SHALL be an FSM with states FETCH, DECODE, MADDR, MRD, MWB, MWR, REXE, RWB, IEXE, IWB, BR, JMP, TRAP; any strobe or select not listed for a state SHALL be 0.
REQ-004 FETCH SHALL drive: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 (add), PCSource=00.
- IRWrite=1 and PCWrite=1 only when mem_ready=1; stay in FETCH while mem_ready=0.
- Go to DECODE when mem_ready=1.
REQ-005 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, EXTOp=00 (sign-extend), then branch on op:
- 0x00 -> REXE.
- 0x08-0x0B -> IEXE with EXTOp=00; 0x0C-0x0F -> IEXE with EXTOp=01 (zero-extend).
- 0x23 / 0x2B -> MADDR.
- 0x04, and 0x05 when EN_BNE=1 -> BR.
- 0x02, and 0x03 when EN_JAL=1 -> JMP.
- anything else -> TRAP.
REQ-006 Per-state behaviour:
- MADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, EXTOp=00; next MRD for 0x23, MWR for 0x2B.
- MRD: MemRead=1, IorD=1; wait on mem_ready, then go to MWB.
- MWB: RegWrite=1, RegDst=00 (rt), MemtoReg=01.
- MWR: MemWrite=1, IorD=1; wait on mem_ready.
- REXE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 (funct).
- RWB: RegWrite=1, RegDst=01 (rd), MemtoReg=00.
- IEXE: ALUSrcA=1, ALUSrcB=10, ALUOp=11 (I-type), with EXTOp held from the DECODE class.
- IWB: RegWrite=1, RegDst=00, MemtoReg=00.
- BR: ALUSrcA=1, ALUSrcB=00, ALUOp=01 (sub), PCWriteCond=1, PCSource=01; BranchNe=1 for op 0x05.
- JMP: PCWrite=1, PCSource=10; for jal additionally RegWrite=1, RegDst=10 ($31), MemtoReg=10 (PC).
REQ-007 MWB, MWR (on the mem_ready=1 cycle), RWB, IWB, BR and JMP SHALL assert instr_done for exactly that cycle and return to FETCH.
REQ-008 retire_cnt SHALL increment by 1 on every cycle with instr_done=1 and SHALL wrap from 2^CNT_W-1 to 0.
REQ-009 Zero-wait latencies SHALL be:
- R-type 4 cycles, I-type 4, lw 5, sw 4, beq/bne 3, j/jal 3.
- Each mem_ready=0 cycle in FETCH, MRD or MWR SHALL add 1 cycle.
REQ-010 TRAP SHALL:
- set illegal=1;
- hold all strobes at 0, with no instr_done and no retire_cnt change;
- remain in TRAP until reset.
REQ-011 op SHALL be sampled only in DECODE and MADDR; op changes in other states SHALL have no effect.
REQ-012 With MEM_WAIT_EN=0, no state SHALL wait on mem_ready.

Reset
REQ-013 rst=0 SHALL immediately force state FETCH, illegal=0 and retire_cnt=0, independent of clk, including mid-instruction.
REQ-014 While rst=0, all strobes SHALL be 0 (FETCH strobes suppressed) and instr_done=0.
REQ-015 After rst rises, the first rising clk edge SHALL evaluate FETCH normally.

Verification
REQ-016 Stimulus: op=0x00, mem_ready=1, from reset. Required: states FETCH, DECODE, REXE, RWB; instr_done in cycle 4 with RegDst=01 and RegWrite=1; retire_cnt=1.
REQ-017 Stimulus: op=0x23, mem_ready=0 for 2 MRD cycles. Required: 7-cycle instruction; MemtoReg=01 and RegWrite=1 only in MWB.
REQ-018 Stimulus: op=0x05 with EN_BNE=1, zero=0. Required: BR asserts PCWriteCond=1, BranchNe=1, PCSource=01, instr_done=1. Same op with EN_BNE=0: TRAP, illegal=1, retire_cnt unchanged.
REQ-019 Stimulus: op=0x03 with EN_JAL=1. Required: JMP cycle shows PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10.
REQ-020 Stimulus: rst pulsed low during MRD and again while in TRAP. Required: immediate FETCH, illegal=0, retire_cnt=0.
REQ-021 Stimulus: CNT_W=4, 16 back-to-back j instructions. Required: retire_cnt goes 15 -> 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: a per-instruction state machine that drives
// the datapath strobes and selects, counts retired instructions and traps on illegal opcodes.
module multicycle_ctrl #(
    parameter logic        MEM_WAIT_EN = 1'b1,
    parameter logic        EN_BNE      = 1'b1,
    parameter logic        EN_JAL      = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             BranchNe,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [1:0]       EXTOp,
    output logic [1:0]       ALUOp,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MADDR, MRD, MWB, MWR, REXE, RWB, IEXE, IWB, BR, JMP, TRAP
    } state_t;

    state_t           state_q, state_d;
    logic             zext_q, zext_d;
    logic             bne_q, bne_d;
    logic             jal_q, jal_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy;
    logic             zero_unused;

    assign rdy         = MEM_WAIT_EN ? mem_ready : 1'b1;
    // The branch decision itself is taken in the datapath from PCWriteCond/BranchNe.
    assign zero_unused = zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH;
            zext_q    <= 1'b0;
            bne_q     <= 1'b0;
            jal_q     <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            zext_q    <= zext_d;
            bne_q     <= bne_d;
            jal_q     <= jal_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        zext_d      = zext_q;
        bne_d       = bne_q;
        jal_d       = jal_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        BranchNe    = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        EXTOp       = 2'b00;
        ALUOp       = 2'b00;
        instr_done  = 1'b0;

        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (rdy) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                // Per-class flags are captured here so later states ignore op.
                case (op) inside
                    6'h00:          state_d = REXE;
                    [6'h08:6'h0B]: begin state_d = IEXE; zext_d = 1'b0; end
                    [6'h0C:6'h0F]: begin state_d = IEXE; zext_d = 1'b1; end
                    6'h23, 6'h2B:   state_d = MADDR;
                    6'h04:         begin state_d = BR; bne_d = 1'b0; end
                    6'h05:         begin state_d = EN_BNE ? BR : TRAP; bne_d = 1'b1; end
                    6'h02:         begin state_d = JMP; jal_d = 1'b0; end
                    6'h03:         begin state_d = EN_JAL ? JMP : TRAP; jal_d = 1'b1; end
                    default:        state_d = TRAP;
                endcase
            end
            MADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op == 6'h2B) ? MWR : MRD;
            end
            MRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (rdy) state_d = MWB;
            end
            MWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b01;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (rdy) begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
            end
            REXE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = RWB;
            end
            RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b01;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            IEXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
                EXTOp   = {1'b0, zext_q};
                state_d = IWB;
            end
            IWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BR: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNe    = bne_q;
                instr_done  = 1'b1;
                state_d     = FETCH;
            end
            JMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                if (jal_q) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase

        // Reset is asynchronous, so the FETCH strobes must be masked combinationally too.
        if (!rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            BranchNe    = 1'b0;
            RegDst      = 2'b00;
            MemtoReg    = 2'b00;
            ALUSrcB     = 2'b00;
            PCSource    = 2'b00;
            EXTOp       = 2'b00;
            ALUOp       = 2'b00;
            instr_done  = 1'b0;
        end
    end

    assign illegal_d  = illegal_q | (state_d == TRAP);
    assign cnt_d      = cnt_q + CNT_W'(instr_done);
    assign illegal    = illegal_q;
    assign retire_cnt = cnt_q;

endmodule
